// File: rtl/sseg_scan_ctrl_if.sv
// Update bus between the system display registers and the scan controller.
// The master owns the digit data and load strobe; the slave reports pending.
interface sseg_scan_ctrl_if #(
    parameter int N_DIGITS = 8
);
    logic [4*N_DIGITS-1:0] hex_in;
    logic [N_DIGITS-1:0]   dp_in;
    logic [N_DIGITS-1:0]   blank_in;
    logic                  load;
    logic                  pending;

    modport master (
        output hex_in,
        output dp_in,
        output blank_in,
        output load,
        input  pending
    );

    modport slave (
        input  hex_in,
        input  dp_in,
        input  blank_in,
        input  load,
        output pending
    );
endinterface

// File: rtl/sseg_scan_ctrl.sv
// N-digit multiplexed seven-segment scanner with hex decode, blanking,
// leading-zero suppression, PWM brightness and frame-synchronous update.
module sseg_scan_ctrl #(
    parameter int N_DIGITS = 8,
    parameter int DWELL    = 12500,
    parameter int PWM_BITS = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    sseg_scan_ctrl_if.slave     upd,
    input  logic                lz_en,
    input  logic [PWM_BITS-1:0] bright,
    output logic                frame_tick,
    output logic [N_DIGITS-1:0] an,
    output logic [7:0]          sseg
);
    localparam int CNT_W = $clog2(DWELL);
    localparam int IDX_W = $clog2(N_DIGITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [PWM_BITS-1:0]   p_q, p_d;
    logic [4*N_DIGITS-1:0] act_hex_q, act_hex_d, sh_hex_q, sh_hex_d;
    logic [N_DIGITS-1:0]   act_dp_q, act_dp_d, sh_dp_q, sh_dp_d;
    logic [N_DIGITS-1:0]   act_blank_q, act_blank_d, sh_blank_q, sh_blank_d;
    logic                  pending_q, pending_d;
    logic [N_DIGITS-1:0]   an_q, an_d;
    logic [7:0]            sseg_q, sseg_d;
    logic                  wrap_s, boundary_s, sup_s;
    logic [3:0]            digit_hex_s;

    // Active-low gfedcba pattern for one hex nibble.
    function automatic logic [6:0] hex7(input logic [3:0] h);
        logic [6:0] seg;
        case (h)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
            default: seg = 7'b1111111;
        endcase
        return seg;
    endfunction

    assign wrap_s     = (cnt_q == CNT_LAST);
    assign boundary_s = wrap_s && (idx_q == IDX_LAST);
    assign frame_tick = boundary_s;
    assign upd.pending = pending_q;
    assign an         = an_q;
    assign sseg       = sseg_q;

    // Scan counters and the shadow/active double buffer.
    always_comb begin
        cnt_d       = cnt_q + CNT_W'(1);
        idx_d       = idx_q;
        p_d         = p_q + PWM_BITS'(1);
        act_hex_d   = act_hex_q;
        act_dp_d    = act_dp_q;
        act_blank_d = act_blank_q;
        sh_hex_d    = sh_hex_q;
        sh_dp_d     = sh_dp_q;
        sh_blank_d  = sh_blank_q;
        pending_d   = pending_q;
        if (wrap_s) begin
            cnt_d = '0;
            if (idx_q == IDX_LAST) begin
                idx_d = '0;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end else begin
            idx_d = idx_q;
        end
        // A load landing on the boundary bypasses the shadow so it is not
        // held back a whole frame.
        if (upd.load) begin
            sh_hex_d   = upd.hex_in;
            sh_dp_d    = upd.dp_in;
            sh_blank_d = upd.blank_in;
            if (boundary_s) begin
                act_hex_d   = upd.hex_in;
                act_dp_d    = upd.dp_in;
                act_blank_d = upd.blank_in;
                pending_d   = 1'b0;
            end else begin
                pending_d   = 1'b1;
            end
        end else if (boundary_s && pending_q) begin
            act_hex_d   = sh_hex_q;
            act_dp_d    = sh_dp_q;
            act_blank_d = sh_blank_q;
            pending_d   = 1'b0;
        end else begin
            pending_d   = pending_q;
        end
    end

    // Anode/segment drive for the digit currently selected.
    always_comb begin
        an_d        = '1;
        sseg_d      = 8'hFF;
        digit_hex_s = act_hex_q[4*idx_q +: 4];
        sup_s       = lz_en && (idx_q != '0);
        for (int i = 0; i < N_DIGITS; i++) begin
            sup_s = sup_s && !((i >= int'(idx_q)) && !act_blank_q[i] &&
                               (act_hex_q[4*i +: 4] != 4'h0));
        end
        if (act_blank_q[idx_q]) begin
            an_d   = '1;
            sseg_d = 8'hFF;
        end else begin
            sseg_d = {~act_dp_q[idx_q], sup_s ? 7'b1111111 : hex7(digit_hex_s)};
            // Count 0 keeps the anode off while the new segments settle.
            if ((cnt_q != '0) && (p_q <= bright)) begin
                an_d = ~(N_DIGITS'(1) << idx_q);
            end else begin
                an_d = '1;
            end
        end
    end

    // State registers; reset leaves the display dark.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q       <= '0;
            idx_q       <= '0;
            p_q         <= '0;
            act_hex_q   <= '0;
            act_dp_q    <= '0;
            act_blank_q <= '1;
            sh_hex_q    <= '0;
            sh_dp_q     <= '0;
            sh_blank_q  <= '1;
            pending_q   <= 1'b0;
            an_q        <= '1;
            sseg_q      <= 8'hFF;
        end else begin
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            p_q         <= p_d;
            act_hex_q   <= act_hex_d;
            act_dp_q    <= act_dp_d;
            act_blank_q <= act_blank_d;
            sh_hex_q    <= sh_hex_d;
            sh_dp_q     <= sh_dp_d;
            sh_blank_q  <= sh_blank_d;
            pending_q   <= pending_d;
            an_q        <= an_d;
            sseg_q      <= sseg_d;
        end
    end
endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Directed plus randomized bench for sseg_scan_ctrl (4 digits, dwell 4, 4-bit PWM)
// against an arithmetic reference model driven by elapsed cycles.
module tb_sseg_scan_ctrl;
    localparam int N     = 4;
    localparam int DW    = 4;
    localparam int PB    = 4;
    localparam int FRAME = N * DW;

    logic          clk     = 1'b0;
    logic          reset_n = 1'b0;
    logic          lz_en   = 1'b0;
    logic [PB-1:0] bright  = 4'hF;
    logic          frame_tick;
    logic [N-1:0]  an;
    logic [7:0]    sseg;

    sseg_scan_ctrl_if #(.N_DIGITS(N)) bus();

    sseg_scan_ctrl #(.N_DIGITS(N), .DWELL(DW), .PWM_BITS(PB)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .upd        (bus),
        .lz_en      (lz_en),
        .bright     (bright),
        .frame_tick (frame_tick),
        .an         (an),
        .sseg       (sseg)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int t     = 0;

    logic [4*N-1:0] m_hex, s_hex;
    logic [N-1:0]   m_dp, m_bl, s_dp, s_bl;
    logic           m_pend;
    logic [6:0]     seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                     7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h (t=%0d)", tag, obs, exp, t);
        end
    endtask

    task automatic model_reset();
        t      = 0;
        m_hex  = '0; s_hex = '0;
        m_dp   = '0; s_dp  = '0;
        m_bl   = '1; s_bl  = '1;
        m_pend = 1'b0;
    endtask

    // Expected {an, sseg} registered from the state at cycle t.
    function automatic logic [N+7:0] expect_out();
        int         idx, cnt, p;
        logic       sup;
        logic [N-1:0] a;
        logic [7:0] s;
        idx = (t / DW) % N;
        cnt = t % DW;
        p   = t % (1 << PB);
        if (m_bl[idx]) return {{N{1'b1}}, 8'hFF};
        sup = lz_en && (idx > 0);
        for (int j = idx; j < N; j++)
            if (!m_bl[j] && (m_hex[4*j +: 4] != 4'h0)) sup = 1'b0;
        s = {~m_dp[idx], sup ? 7'h7F : seg_tab[m_hex[4*idx +: 4]]};
        a = '1;
        if ((cnt != 0) && (p <= int'(bright))) a[idx] = 1'b0;
        return {a, s};
    endfunction

    task automatic cycle();
        logic [N+7:0] e;
        logic         bnd;
        bnd = ((t % FRAME) == FRAME - 1);
        chk("frame_tick", 32'(frame_tick), 32'(bnd));
        chk("pending", 32'(bus.pending), 32'(m_pend));
        e = expect_out();
        if (bus.load) begin
            s_hex = bus.hex_in; s_dp = bus.dp_in; s_bl = bus.blank_in;
            if (bnd) begin
                m_hex = bus.hex_in; m_dp = bus.dp_in; m_bl = bus.blank_in;
                m_pend = 1'b0;
            end else begin
                m_pend = 1'b1;
            end
        end else if (bnd && m_pend) begin
            m_hex = s_hex; m_dp = s_dp; m_bl = s_bl;
            m_pend = 1'b0;
        end
        @(posedge clk);
        #1;
        t++;
        bus.load = 1'b0;
        chk("an", 32'(an), 32'(e[N+7:8]));
        chk("sseg", 32'(sseg), 32'(e[7:0]));
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic run_to(input int ph);
        while ((t % FRAME) != ph) cycle();
    endtask

    task automatic do_load(input logic [4*N-1:0] h, input logic [N-1:0] dp, input logic [N-1:0] bl);
        bus.hex_in = h; bus.dp_in = dp; bus.blank_in = bl; bus.load = 1'b1;
        cycle();
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
    endtask

    initial begin
        bus.hex_in = '0; bus.dp_in = '0; bus.blank_in = '0; bus.load = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_sseg", 32'(sseg), 32'hFF);
        chk("rst_tick", 32'(frame_tick), 32'h0);
        release_reset();

        // Dark display for two frames with no load.
        run(2 * FRAME);

        // Hex 12AF with dp on digit 2 at full brightness.
        do_load(16'h12AF, 4'b0100, 4'b0000);
        run(3 * FRAME);

        // Leading-zero suppression.
        lz_en = 1'b1;
        do_load(16'h0030, 4'b0000, 4'b0000);
        run(2 * FRAME);

        // Two mid-frame loads; last wins at the boundary.
        run_to(5);
        do_load(16'h1111, 4'b0000, 4'b0000);
        run(2);
        do_load(16'h2222, 4'b0000, 4'b0000);
        run(FRAME + 4);
        // Load on the boundary cycle goes straight to active.
        run_to(FRAME - 1);
        do_load(16'h3333, 4'b1000, 4'b0000);
        run(FRAME);

        // Reduced brightness.
        bright = 4'h3;
        run(256);

        // Randomized loads, blanking, lz_en and brightness.
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(7, 0) == 0) begin
                for (int d = 0; d < N; d++)
                    bus.hex_in[4*d +: 4] = ($urandom_range(2, 0) == 0) ? 4'h0 : 4'($urandom_range(15, 0));
                bus.dp_in    = 4'($urandom_range(15, 0));
                bus.blank_in = 4'($urandom_range(15, 0)) & 4'($urandom_range(15, 0));
                bus.load     = 1'b1;
            end
            if ($urandom_range(31, 0) == 0) lz_en = ~lz_en;
            if ($urandom_range(31, 0) == 0) bright = 4'($urandom_range(15, 0));
            cycle();
        end

        // Asynchronous reset in the middle of a dwell.
        bright = 4'hF;
        do_load(16'h8888, 4'b1111, 4'b0000);
        run(FRAME);
        while ((t % DW) != 2) cycle();
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_an", 32'(an), 32'hF);
        chk("async_sseg", 32'(sseg), 32'hFF);
        chk("async_pend", 32'(bus.pending), 32'h0);
        chk("async_tick", 32'(frame_tick), 32'h0);
        release_reset();
        run(2 * FRAME);
        do_load(16'h0123, 4'b0001, 4'b0000);
        run(2 * FRAME);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
